// File: rtl/tdm_demux8_if.sv
// Serial slot input and parallel frame output of the TDM receive link.
interface tdm_demux8_if #(
   parameter int W = 1
);
   logic           en;
   logic           sync;
   logic [W-1:0]   din;
   logic [8*W-1:0] d;
   logic           frame_valid;
   logic [2:0]     slot;
   logic           locked;
   logic           sync_err;

   // Link side: drives slots, observes rebuilt frames
   modport master (
      output en, sync, din,
      input  d, frame_valid, slot, locked, sync_err
   );

   // Demux side
   modport slave (
      input  en, sync, din,
      output d, frame_valid, slot, locked, sync_err
   );
endinterface

// File: rtl/tdm_demux8.sv
// 8-channel TDM receive demux: gathers one slot per strobe into a shadow
// buffer and publishes all 8 channel words atomically once slot 7 lands.

// One channel: a shadow entry filled mid-frame and the published word.
// The last channel has no use for its shadow; it publishes straight from
// din on the slot-7 edge so back-to-back frames need no dead cycle.
module tdm_demux8_lane #(
   parameter int W    = 1,
   parameter bit LAST = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr,
   input  logic         pub,
   input  logic [W-1:0] din,
   output logic [W-1:0] q
);
   logic [W-1:0] shadow;

   // Shadow entry: written on this channel's slot, kept across errors
   always_ff @(posedge clk) begin
      if (rst)     shadow <= '0;
      else if (wr) shadow <= din;
   end

   // Published word: only moves when a complete frame is committed
   always_ff @(posedge clk) begin
      if (rst)      q <= '0;
      else if (pub) q <= LAST ? din : shadow;
   end
endmodule

module tdm_demux8 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   tdm_demux8_if.slave  bus
);
   typedef enum logic {HUNT, LOCKED} state_t;

   state_t              state, state_nx;
   logic [2:0]          slot, slot_nx;
   logic                fv, fv_nx;
   logic                err, err_nx;
   logic [7:0]          wr_sel;
   logic                publish;
   logic [7:0][W-1:0]   d_lane;

   // State, slot pointer and the two single-cycle pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
         slot  <= 3'd0;
         fv    <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         slot  <= slot_nx;
         fv    <= fv_nx;
         err   <= err_nx;
      end
   end

   // Slot sequencing: decide shadow write, publish and sync violations
   always_comb begin
      state_nx = state;
      slot_nx  = slot;
      wr_sel   = '0;
      publish  = 1'b0;
      fv_nx    = 1'b0;
      err_nx   = 1'b0;
      if (bus.en) begin
         unique case (state)
            HUNT: begin
               // Samples before the first sync carry no frame position
               if (bus.sync) begin
                  wr_sel[0] = 1'b1;
                  slot_nx   = 3'd1;
                  state_nx  = LOCKED;
               end
            end
            LOCKED: begin
               if (slot == 3'd0) begin
                  if (bus.sync) begin
                     wr_sel[0] = 1'b1;
                     slot_nx   = 3'd1;
                  end else begin
                     // Lost alignment: drop the sample and re-hunt
                     err_nx   = 1'b1;
                     slot_nx  = 3'd0;
                     state_nx = HUNT;
                  end
               end else if (bus.sync) begin
                  // Early sync: abandon the partial frame, restart on this sample
                  err_nx    = 1'b1;
                  wr_sel[0] = 1'b1;
                  slot_nx   = 3'd1;
               end else if (slot == 3'd7) begin
                  publish = 1'b1;
                  fv_nx   = 1'b1;
                  slot_nx = 3'd0;
               end else begin
                  wr_sel[slot] = 1'b1;
                  slot_nx      = 3'(slot + 3'd1);
               end
            end
            default: state_nx = HUNT;
         endcase
      end
   end

   // Per-channel shadow/publish registers
   generate
      for (genvar k = 0; k < 8; k++) begin : g_lane
         tdm_demux8_lane #(
            .W    (W),
            .LAST (k == 7)
         ) u_lane (
            .clk (clk),
            .rst (rst),
            .wr  (wr_sel[k]),
            .pub (publish),
            .din (bus.din),
            .q   (d_lane[k])
         );
      end
   endgenerate

   assign bus.d           = d_lane;
   assign bus.frame_valid = fv;
   assign bus.sync_err    = err;
   assign bus.slot        = slot;
   assign bus.locked      = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboard bench for tdm_demux8 (W=8): stimulus pushes expected frames and
// error pulses tagged with the cycle they must appear; a monitor pops them.
module tb_tdm_demux8;
   localparam int W = 8;

   typedef struct {
      int          cyc;
      logic [63:0] d;
   } fv_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   fails  = 0;

   fv_exp_t fv_q[$];
   int      err_q[$];

   tdm_demux8_if #(.W(W)) bus ();

   tdm_demux8 #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every frame_valid / sync_err pulse must match a queued expectation
   always @(negedge clk) begin
      if (bus.frame_valid) begin
         checks++;
         if (fv_q.size() == 0 || fv_q[0].cyc != cyc) begin
            fails++;
            $display("FAIL unexpected_frame_valid: got pulse at cycle %0d expected none", cyc);
         end else begin
            fv_exp_t e;
            e = fv_q.pop_front();
            if (bus.d !== e.d) begin
               fails++;
               $display("FAIL frame_data: got %h expected %h", bus.d, e.d);
            end
         end
      end else if (fv_q.size() != 0 && fv_q[0].cyc == cyc) begin
         checks++;
         fails++;
         $display("FAIL missing_frame_valid: got 0 at cycle %0d expected 1", cyc);
         void'(fv_q.pop_front());
      end
      if (bus.sync_err) begin
         checks++;
         if (err_q.size() == 0 || err_q[0] != cyc) begin
            fails++;
            $display("FAIL unexpected_sync_err: got pulse at cycle %0d expected none", cyc);
         end else void'(err_q.pop_front());
      end else if (err_q.size() != 0 && err_q[0] == cyc) begin
         checks++;
         fails++;
         $display("FAIL missing_sync_err: got 0 at cycle %0d expected 1", cyc);
         void'(err_q.pop_front());
      end
      if (bus.sync_err && bus.frame_valid) begin
         fails++;
         $display("FAIL pulse_overlap: got both 1 expected at most one");
      end
   end

   task automatic drive(input logic e, input logic s, input logic [7:0] x);
      bus.en   = e;
      bus.sync = s;
      bus.din  = x;
      @(posedge clk);
      #1;
   endtask

   task automatic push_fv(input logic [63:0] d);
      fv_exp_t e;
      e.cyc = cyc + 1;
      e.d   = d;
      fv_q.push_back(e);
   endtask

   task automatic push_err();
      err_q.push_back(cyc + 1);
   endtask

   // Full 8-slot frame from base..base+7; optional idle strobes after slots 2 and 5
   task automatic send_frame(input logic [7:0] base, input logic [63:0] exp, input bit gaps);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) push_fv(exp);
         drive(1'b1, i == 0, 8'(base + 8'(i)));
         if (gaps && (i == 2 || i == 5)) begin
            drive(1'b0, 1'($urandom), 8'($urandom));
            chk("gap_slot_hold", 64'(bus.slot), 64'(i + 1));
         end
      end
   endtask

   initial begin
      bus.en = 1'b0; bus.sync = 1'b0; bus.din = '0;
      // 1: reset with random inputs
      rst = 1'b1;
      for (int i = 0; i < 2; i++) drive(1'($urandom), 1'($urandom), 8'($urandom));
      chk("rst_d", bus.d, 64'h0);
      chk("rst_slot", 64'(bus.slot), 64'd0);
      chk("rst_locked", 64'(bus.locked), 64'd0);
      chk("rst_fv", 64'(bus.frame_valid), 64'd0);
      chk("rst_err", 64'(bus.sync_err), 64'd0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00);

      // 2: continuous streaming, 3 frames back to back
      for (int f = 0; f < 3; f++) begin
         send_frame(8'hA0, 64'hA7A6A5A4A3A2A1A0, 1'b0);
         chk("stream_slot_wrap", 64'(bus.slot), 64'd0);
      end
      chk("stream_locked", 64'(bus.locked), 64'd1);

      // 3: gapped strobe, different data so the publish is visible
      send_frame(8'hB0, 64'hB7B6B5B4B3B2B1B0, 1'b1);
      drive(1'b0, 1'b0, 8'h55);
      chk("gap_d_hold", bus.d, 64'hB7B6B5B4B3B2B1B0);

      // 4: early sync at slot 4
      for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 8'(8'hC0 + 8'(i)));
      push_err();
      drive(1'b1, 1'b1, 8'hD0);
      chk("early_d_kept", bus.d, 64'hB7B6B5B4B3B2B1B0);
      chk("early_slot", 64'(bus.slot), 64'd1);
      chk("early_locked", 64'(bus.locked), 64'd1);
      for (int i = 1; i < 8; i++) begin
         if (i == 7) push_fv(64'hD7D6D5D4D3D2D1D0);
         drive(1'b1, 1'b0, 8'(8'hD0 + 8'(i)));
      end

      // 5: missing sync on slot 0
      push_err();
      drive(1'b1, 1'b0, 8'hE0);
      chk("miss_locked", 64'(bus.locked), 64'd0);
      drive(1'b1, 1'b0, 8'hE1);
      drive(1'b1, 1'b0, 8'hE2);
      chk("hunt_ignore_locked", 64'(bus.locked), 64'd0);
      chk("hunt_ignore_slot", 64'(bus.slot), 64'd0);
      send_frame(8'h10, 64'h1716151413121110, 1'b0);

      // 6: reset mid-frame at slot 5
      for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 8'(8'h20 + 8'(i)));
      chk("mid_slot", 64'(bus.slot), 64'd5);
      rst = 1'b1;
      drive(1'b1, 1'b0, 8'h25);
      chk("midrst_d", bus.d, 64'h0);
      chk("midrst_locked", 64'(bus.locked), 64'd0);
      chk("midrst_slot", 64'(bus.slot), 64'd0);
      rst = 1'b0;
      send_frame(8'h30, 64'h3736353433323130, 1'b0);

      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      chk("final_d", bus.d, 64'h3736353433323130);
      chk("fv_queue_drained", 64'(fv_q.size()), 64'd0);
      chk("err_queue_drained", 64'(err_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
